parking_exit_gate: RTL and testbench
====================================

# parking_exit_gate

Exit-side controller for the parking system, the counterpart of the entry gate. It maintains lot occupancy from the entry gate's car-entered strobe and the exit gate's clear sensor. It validates the 2×2-bit exit code, drives the exit barrier and LEDs, and shows free spaces on two seven-segment digits. It sits beside the entry controller and shares its clock, reset, code-input and display conventions.

## Interface
- CAPACITY, 8: lot size, 1..99
- EXIT_CODE_1, 2'b01: required pass_1 value
- EXIT_CODE_2, 2'b10: required pass_2 value
- MAX_TRIES, 3: wrong codes allowed before lockout, 1..7
- GATE_TICKS, 50: OPEN timeout in cycles
- LOCK_TICKS, 100: LOCKOUT duration in cycles
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- car_entered  in  1  one-cycle strobe from the entry gate: a car passed in
- sensor_exit  in  1  level: car present at the exit barrier
- sensor_clear  in  1  one-cycle strobe: car has passed the exit barrier
- pass_1  in  2  exit code digit 1
- pass_2  in  2  exit code digit 2
- pass_valid  in  1  one-cycle strobe: pass_1/pass_2 are valid this cycle
- gate_open  out  1  barrier raise command
- green_led  out  1  code accepted
- red_led  out  1  code rejected or locked out
- lot_full  out  1  occupancy == CAPACITY
- occupancy  out  7  cars currently in the lot
- hex_1  out  7  tens digit of free spaces, active-low gfedcba
- hex_2  out  7  units digit of free spaces, active-low gfedcba

## Operation
- States: IDLE, WAIT_PASS, WRONG_PASS, OPEN, LOCKOUT.
- IDLE goes to WAIT_PASS when sensor_exit=1 and occupancy>0. With occupancy=0, sensor_exit is ignored.
- WAIT_PASS and WRONG_PASS behave the same:
  - pass_valid with pass_1==EXIT_CODE_1 and pass_2==EXIT_CODE_2 goes to OPEN and clears tries.
  - pass_valid with a mismatch increments tries. If the new tries equals MAX_TRIES, go to LOCKOUT; otherwise go to WRONG_PASS.
  - sensor_exit=0 with no pass_valid returns to IDLE and clears tries.
  - pass_valid takes priority over sensor_exit falling in the same cycle.
- OPEN:
  - sensor_clear decrements occupancy and goes to IDLE.
  - When the timer reaches GATE_TICKS-1 without sensor_clear, go to IDLE with no decrement.
- LOCKOUT ignores all inputs except reset and car_entered. It goes to IDLE and clears tries after LOCK_TICKS cycles.
- Occupancy update:
  - car_entered increments occupancy, saturating at CAPACITY.
  - Exit clear decrements occupancy, never below 0.
  - Both in the same cycle leave occupancy unchanged.
  - The count is updated in every state.
- Free spaces = CAPACITY − occupancy, split into tens and units and decoded to segments. 0 = 7'b1000000; no blanking.
- Moore outputs:
  - gate_open = green_led = (state==OPEN)
  - red_led = (state==WRONG_PASS or LOCKOUT)
  - lot_full is combinational from the occupancy register.

## Timing
- Reset values: state IDLE, tries 0, timer 0, occupancy 0, gate_open/green_led/red_led/lot_full 0. hex_1/hex_2 show CAPACITY (08 at default).
- Reset asserted mid-operation returns to these values on the next edge and overrides all inputs.
- Inputs are sampled on the rising edge. State and occupancy update on that edge. Outputs reflect the new state in the same cycle, so latency is 1 cycle from strobe to output.
- Timer:
  - Clears on every state change.
  - In OPEN it counts 0..GATE_TICKS-1, so the gate is high for exactly GATE_TICKS cycles on timeout.
  - In LOCKOUT it counts 0..LOCK_TICKS-1, so red_led is high for exactly LOCK_TICKS cycles.
- Strobes longer than one cycle count once per high cycle. Upstream guarantees single-cycle strobes.

## Structure
- Package parking_pkg holds:
  - the state enum (shared encoding style with the entry controller);
  - the seven-segment constants for digits 0–9;
  - the free-space split helper.
- Sub-module parking_seg7: 4-bit BCD to 7-bit active-low segment decoder. It is instantiated twice and is reusable by the entry controller.
- Timer width is $clog2(max(GATE_TICKS, LOCK_TICKS)). tries is 3 bits.

## Test plan
- Reset, then two car_entered strobes: occupancy=2, hex_1=7'b1000000, hex_2=7'b0000010 ("06"), all LEDs 0.
- occupancy=2, sensor_exit=1, pass_valid with 01/10, then sensor_clear after 5 cycles: green_led and gate_open high for 6 cycles, then occupancy=1 and state IDLE.
- Codes 00/00 three times in WAIT_PASS: red_led high from the first strobe; after the third strobe, LOCKOUT holds red_led for 100 cycles; a correct code during LOCKOUT has no effect.
- OPEN with no sensor_clear: gate_open high for exactly 50 cycles, then low; occupancy unchanged.
- Eight car_entered strobes: lot_full=1, display "00". A ninth strobe keeps occupancy at 8. car_entered and sensor_clear in the same cycle leave occupancy at 8.
- sensor_exit=1 with occupancy=0: state stays IDLE. Reset asserted in OPEN: gate_open=0 on the next cycle and occupancy=0.

Source files
------------

// File: rtl/parking_pkg.sv
// Shared types and helpers for the parking gate controllers: FSM state,
// seven-segment glyphs and the free-space digit split.
package parking_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_PASS,
    WRONG_PASS,
    OPEN,
    LOCKOUT
  } state_t;

  // Active-low gfedcba glyphs
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // {tens, units} of a 0..99 value
  function automatic logic [7:0] free_split(input logic [6:0] v);
    return {4'(v / 7'd10), 4'(v % 7'd10)};
  endfunction

endpackage

// File: rtl/parking_seg7.sv
// BCD digit to active-low seven-segment pattern; non-decimal codes go dark.
module parking_seg7
  import parking_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/parking_exit_gate.sv
// Exit-side parking controller: code check, barrier FSM with timeout and
// lockout, lot occupancy tracking and free-space display.
module parking_exit_gate
  import parking_pkg::*;
#(
  parameter int         CAPACITY    = 8,
  parameter logic [1:0] EXIT_CODE_1 = 2'b01,
  parameter logic [1:0] EXIT_CODE_2 = 2'b10,
  parameter int         MAX_TRIES   = 3,
  parameter int         GATE_TICKS  = 50,
  parameter int         LOCK_TICKS  = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       car_entered,
  input  logic       sensor_exit,
  input  logic       sensor_clear,
  input  logic [1:0] pass_1,
  input  logic [1:0] pass_2,
  input  logic       pass_valid,
  output logic       gate_open,
  output logic       green_led,
  output logic       red_led,
  output logic       lot_full,
  output logic [6:0] occupancy,
  output logic [6:0] hex_1,
  output logic [6:0] hex_2
);

  localparam int TMAX = (GATE_TICKS > LOCK_TICKS) ? GATE_TICKS : LOCK_TICKS;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [6:0] CAP = 7'(CAPACITY);

  state_t          state, state_n;
  logic [2:0]      tries, tries_n;
  logic [TW-1:0]   timer;
  logic            dec;
  logic [6:0]      free;
  logic [7:0]      digits;

  always_comb begin
    state_n = state;
    tries_n = tries;
    dec     = 1'b0;
    case (state)
      IDLE:
        if (sensor_exit && occupancy != 7'd0) state_n = WAIT_PASS;
      WAIT_PASS, WRONG_PASS: begin
        // a code strobe wins over the car backing away in the same cycle
        if (pass_valid) begin
          if (pass_1 == EXIT_CODE_1 && pass_2 == EXIT_CODE_2) begin
            state_n = OPEN;
            tries_n = 3'd0;
          end else begin
            tries_n = tries + 3'd1;
            state_n = (tries_n == 3'(MAX_TRIES)) ? LOCKOUT : WRONG_PASS;
          end
        end else if (!sensor_exit) begin
          state_n = IDLE;
          tries_n = 3'd0;
        end
      end
      OPEN:
        if (sensor_clear) begin
          dec     = 1'b1;
          state_n = IDLE;
        end else if (timer == TW'(GATE_TICKS - 1)) begin
          state_n = IDLE;
        end
      LOCKOUT:
        if (timer == TW'(LOCK_TICKS - 1)) begin
          state_n = IDLE;
          tries_n = 3'd0;
        end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      tries     <= 3'd0;
      timer     <= '0;
      occupancy <= 7'd0;
      gate_open <= 1'b0;
      green_led <= 1'b0;
      red_led   <= 1'b0;
    end else begin
      state <= state_n;
      tries <= tries_n;
      if (state_n != state || !(state == OPEN || state == LOCKOUT))
        timer <= '0;
      else
        timer <= timer + TW'(1);
      // simultaneous entry and exit cancel out
      case ({car_entered, dec})
        2'b10: if (occupancy < CAP) occupancy <= occupancy + 7'd1;
        2'b01: if (occupancy != 7'd0) occupancy <= occupancy - 7'd1;
        default: ;
      endcase
      gate_open <= (state_n == OPEN);
      green_led <= (state_n == OPEN);
      red_led   <= (state_n == WRONG_PASS) || (state_n == LOCKOUT);
    end
  end

  assign lot_full = (occupancy == CAP);
  assign free     = CAP - occupancy;
  assign digits   = free_split(free);

  parking_seg7 u_tens  (.bcd(digits[7:4]), .seg(hex_1));
  parking_seg7 u_units (.bcd(digits[3:0]), .seg(hex_2));

endmodule

// File: tb/tb_parking_exit_gate.sv
// Self-checking bench for parking_exit_gate: vector table, directed corner
// sequences and randomized traffic against a behavioural model.
module tb_parking_exit_gate;

  localparam int         CAP  = 8;
  localparam logic [1:0] C1   = 2'b01;
  localparam logic [1:0] C2   = 2'b10;
  localparam int         MAXT = 3;
  localparam int         GT   = 50;
  localparam int         LT   = 100;

  localparam int M_IDLE = 0, M_WAIT = 1, M_WRONG = 2, M_OPEN = 3, M_LOCK = 4;

  logic clk = 1'b0;
  logic reset, car_entered, sensor_exit, sensor_clear, pass_valid;
  logic [1:0] pass_1, pass_2;
  logic gate_open, green_led, red_led, lot_full;
  logic [6:0] occupancy, hex_1, hex_2;

  parking_exit_gate #(
    .CAPACITY(CAP), .EXIT_CODE_1(C1), .EXIT_CODE_2(C2),
    .MAX_TRIES(MAXT), .GATE_TICKS(GT), .LOCK_TICKS(LT)
  ) dut (
    .clk(clk), .reset(reset), .car_entered(car_entered),
    .sensor_exit(sensor_exit), .sensor_clear(sensor_clear),
    .pass_1(pass_1), .pass_2(pass_2), .pass_valid(pass_valid),
    .gate_open(gate_open), .green_led(green_led), .red_led(red_led),
    .lot_full(lot_full), .occupancy(occupancy), .hex_1(hex_1), .hex_2(hex_2)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [6:0] glyph [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                             7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  // behavioural model: mode, wrong-code count, cycles spent in mode, cars
  int m_mode = M_IDLE, m_tries = 0, m_age = 0, m_occ = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, car, ex, clr, pv, input logic [1:0] p1, p2);
    int nm;
    int leave;
    if (r) begin
      m_mode = M_IDLE; m_tries = 0; m_age = 0; m_occ = 0;
      return;
    end
    nm = m_mode;
    leave = 0;
    case (m_mode)
      M_IDLE: if (ex && m_occ > 0) nm = M_WAIT;
      M_WAIT, M_WRONG:
        if (pv) begin
          if (p1 == C1 && p2 == C2) begin nm = M_OPEN; m_tries = 0; end
          else begin
            m_tries = m_tries + 1;
            nm = (m_tries == MAXT) ? M_LOCK : M_WRONG;
          end
        end else if (!ex) begin nm = M_IDLE; m_tries = 0; end
      M_OPEN:
        if (clr) begin leave = 1; nm = M_IDLE; end
        else if (m_age + 1 == GT) nm = M_IDLE;
      M_LOCK:
        if (m_age + 1 == LT) begin nm = M_IDLE; m_tries = 0; end
      default: nm = M_IDLE;
    endcase
    m_age = (nm == m_mode) ? m_age + 1 : 0;
    m_mode = nm;
    m_occ = m_occ + int'(car) - leave;
    if (m_occ > CAP) m_occ = CAP;
    if (m_occ < 0) m_occ = 0;
  endtask

  task automatic check_model();
    chk("gate_open", gate_open, m_mode == M_OPEN);
    chk("green_led", green_led, m_mode == M_OPEN);
    chk("red_led", red_led, m_mode == M_WRONG || m_mode == M_LOCK);
    chk("occupancy", occupancy, m_occ);
    chk("lot_full", lot_full, m_occ == CAP);
    chk("hex_1", hex_1, glyph[(CAP - m_occ) / 10]);
    chk("hex_2", hex_2, glyph[(CAP - m_occ) % 10]);
  endtask

  task automatic cycle(input bit r, car, ex, clr, pv, input logic [1:0] p1, p2);
    reset = r; car_entered = car; sensor_exit = ex; sensor_clear = clr;
    pass_valid = pv; pass_1 = p1; pass_2 = p2;
    @(posedge clk);
    model_step(r, car, ex, clr, pv, p1, p2);
    #1;
    check_model();
  endtask

  typedef struct {
    bit rst, car, ex, clr, pv;
    logic [1:0] p1, p2;
    bit gate, red;
    int occ;
    logic [6:0] h1, h2;
  } vec_t;

  vec_t tbl [9];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit saw;
    reset = 1'b1; car_entered = 0; sensor_exit = 0; sensor_clear = 0;
    pass_valid = 0; pass_1 = 2'b00; pass_2 = 2'b00;

    //         rst car ex clr pv  p1     p2     gate red occ h1     h2
    tbl[0] = '{1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 7'h40, 7'h00};
    tbl[1] = '{0, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 1, 7'h40, 7'h78};
    tbl[2] = '{0, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2, 7'h40, 7'h02};
    tbl[3] = '{0, 0, 1, 0, 0, 2'b00, 2'b00, 0, 0, 2, 7'h40, 7'h02};
    tbl[4] = '{0, 0, 1, 0, 1, 2'b00, 2'b00, 0, 1, 2, 7'h40, 7'h02};
    tbl[5] = '{0, 0, 1, 0, 1, 2'b01, 2'b10, 1, 0, 2, 7'h40, 7'h02};
    tbl[6] = '{0, 0, 1, 0, 0, 2'b00, 2'b00, 1, 0, 2, 7'h40, 7'h02};
    tbl[7] = '{0, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 1, 7'h40, 7'h78};
    tbl[8] = '{0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 1, 7'h40, 7'h78};

    for (int i = 0; i < 9; i++) begin
      cycle(tbl[i].rst, tbl[i].car, tbl[i].ex, tbl[i].clr, tbl[i].pv, tbl[i].p1, tbl[i].p2);
      chk($sformatf("vec%0d_gate", i), gate_open, tbl[i].gate);
      chk($sformatf("vec%0d_red", i), red_led, tbl[i].red);
      chk($sformatf("vec%0d_occ", i), occupancy, tbl[i].occ);
      chk($sformatf("vec%0d_hex1", i), hex_1, tbl[i].h1);
      chk($sformatf("vec%0d_hex2", i), hex_2, tbl[i].h2);
    end

    // open, then clear five cycles later: six cycles of gate
    cycle(0, 0, 1, 0, 0, 2'b00, 2'b00);
    cycle(0, 0, 1, 0, 1, C1, C2);
    n = gate_open ? 1 : 0;
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 1, 0, 0, 2'b00, 2'b00);
      if (gate_open) n++;
    end
    cycle(0, 0, 0, 1, 0, 2'b00, 2'b00);
    chk("clear_gate_len", n, 6);
    chk("clear_gate_low", gate_open, 0);
    chk("clear_occ", occupancy, 0);

    // three wrong codes -> lockout of LT cycles, correct code ignored
    cycle(0, 1, 0, 0, 0, 2'b00, 2'b00);
    cycle(0, 1, 0, 0, 0, 2'b00, 2'b00);
    cycle(0, 0, 1, 0, 0, 2'b00, 2'b00);
    cycle(0, 0, 1, 0, 1, 2'b00, 2'b00);
    chk("red_first_wrong", red_led, 1);
    cycle(0, 0, 1, 0, 1, 2'b00, 2'b00);
    cycle(0, 0, 1, 0, 1, 2'b00, 2'b00);
    n = red_led ? 1 : 0;
    saw = 0;
    for (int i = 0; i < 300 && red_led; i++) begin
      cycle(0, 0, (i % 3) == 0, (i % 11) == 0, (i % 10) == 0, C1, C2);
      if (red_led) n++;
      if (gate_open) saw = 1;
    end
    chk("lockout_len", n, LT);
    chk("lockout_no_gate", saw, 0);
    chk("lockout_occ", occupancy, 2);

    // open with no clear: times out after GT cycles
    cycle(0, 0, 0, 0, 0, 2'b00, 2'b00);
    cycle(0, 0, 1, 0, 0, 2'b00, 2'b00);
    cycle(0, 0, 1, 0, 1, C1, C2);
    n = gate_open ? 1 : 0;
    for (int i = 0; i < 300 && gate_open; i++) begin
      cycle(0, 0, 0, 0, 0, 2'b00, 2'b00);
      if (gate_open) n++;
    end
    chk("timeout_len", n, GT);
    chk("timeout_occ", occupancy, 2);

    // fill the lot and saturate
    cycle(1, 0, 0, 0, 0, 2'b00, 2'b00);
    for (int i = 0; i < CAP; i++) cycle(0, 1, 0, 0, 0, 2'b00, 2'b00);
    chk("full_flag", lot_full, 1);
    chk("full_hex1", hex_1, 7'h40);
    chk("full_hex2", hex_2, 7'h40);
    cycle(0, 1, 0, 0, 0, 2'b00, 2'b00);
    chk("full_saturate", occupancy, CAP);
    cycle(0, 1, 0, 1, 0, 2'b00, 2'b00);
    chk("full_idle_both", occupancy, CAP);
    cycle(0, 0, 1, 0, 0, 2'b00, 2'b00);
    cycle(0, 0, 1, 0, 1, C1, C2);
    cycle(0, 1, 1, 1, 0, 2'b00, 2'b00);
    chk("full_open_both", occupancy, CAP);
    chk("full_open_both_gate", gate_open, 0);

    // empty lot ignores the exit sensor
    cycle(1, 0, 0, 0, 0, 2'b00, 2'b00);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, 0, 2'b00, 2'b00);
    cycle(0, 0, 1, 0, 1, C1, C2);
    chk("empty_gate", gate_open, 0);
    chk("empty_red", red_led, 0);

    // reset while the gate is open
    cycle(0, 1, 0, 0, 0, 2'b00, 2'b00);
    cycle(0, 1, 0, 0, 0, 2'b00, 2'b00);
    cycle(0, 0, 1, 0, 0, 2'b00, 2'b00);
    cycle(0, 0, 1, 0, 1, C1, C2);
    chk("pre_reset_gate", gate_open, 1);
    cycle(1, 1, 1, 1, 0, 2'b00, 2'b00);
    chk("reset_gate", gate_open, 0);
    chk("reset_occ", occupancy, 0);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      bit r, car, ex, clr, pv;
      logic [1:0] p1, p2;
      r   = ($urandom_range(0, 599) == 0);
      car = ($urandom_range(0, 5) == 0);
      ex  = ($urandom_range(0, 9) < 8);
      clr = ($urandom_range(0, 19) == 0);
      pv  = ($urandom_range(0, 6) == 0);
      p1  = $urandom_range(0, 1) ? C1 : 2'($urandom);
      p2  = $urandom_range(0, 1) ? C2 : 2'($urandom);
      cycle(r, car, ex, clr, pv, p1, p2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
